// File: rtl/me_pkg.sv
// Shared sizing helpers and FSM state type for the motion-estimation result path.
package me_pkg;

  function automatic int unsigned range_f(input int unsigned tb_length, input int unsigned sw_length);
    return sw_length - tb_length + 1;
  endfunction

  function automatic int unsigned cnt_width_f(input int unsigned tb_length, input int unsigned sw_length);
    int unsigned r;
    r = range_f(tb_length, sw_length);
    return $clog2(r * r);
  endfunction

  function automatic int unsigned sad_width_f(input int unsigned tb_length, input int unsigned pe_out_width);
    return $clog2(tb_length * tb_length) + pe_out_width;
  endfunction

  function automatic int unsigned cw_f(input int unsigned tb_length, input int unsigned sw_length);
    return $clog2(range_f(tb_length, sw_length));
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/me_result_unpack_if.sv
// Result bus between me_top-side inputs and the decoded display outputs.
interface me_result_unpack_if #(
  parameter int unsigned TB_LENGTH    = 16,
  parameter int unsigned SW_LENGTH    = 64,
  parameter int unsigned PE_OUT_WIDTH = 8,
  parameter int unsigned CYC_WIDTH    = 24
);
  localparam int unsigned CNT_WIDTH = me_pkg::cnt_width_f(TB_LENGTH, SW_LENGTH);
  localparam int unsigned SAD_WIDTH = me_pkg::sad_width_f(TB_LENGTH, PE_OUT_WIDTH);
  localparam int unsigned CW        = me_pkg::cw_f(TB_LENGTH, SW_LENGTH);

  logic                    req;
  logic                    ack;
  logic [SAD_WIDTH-1:0]    min_sad;
  logic [CNT_WIDTH-1:0]    min_mvec;
  logic                    out_valid;
  logic [SAD_WIDTH-1:0]    sad_q;
  logic [CW-1:0]           mvec_x;
  logic [CW-1:0]           mvec_y;
  logic signed [CW:0]      dx;
  logic signed [CW:0]      dy;
  logic [CYC_WIDTH-1:0]    cycles;
  logic                    err;

  modport master (
    output req, ack, min_sad, min_mvec,
    input  out_valid, sad_q, mvec_x, mvec_y, dx, dy, cycles, err
  );

  modport slave (
    input  req, ack, min_sad, min_mvec,
    output out_valid, sad_q, mvec_x, mvec_y, dx, dy, cycles, err
  );
endinterface

// File: rtl/me_idx_divider.sv
// Iterative divide-by-RANGE: one compare-subtract per cycle after start.
// done/range_err are combinational in the finishing cycle so the caller can
// register the result on the same edge.
module me_idx_divider #(
  parameter int unsigned RANGE     = 49,
  parameter int unsigned CNT_WIDTH = 12,
  parameter int unsigned CW        = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] dividend,
  output logic                 done,
  output logic [CW-1:0]        quot,
  output logic [CW-1:0]        rem,
  output logic                 range_err
);
  localparam logic [CNT_WIDTH-1:0] DIV = CNT_WIDTH'(RANGE);
  localparam logic [CNT_WIDTH:0]   LIM = (CNT_WIDTH+1)'(RANGE * RANGE);

  logic [CNT_WIDTH-1:0] rem_q;
  logic [CW-1:0]        quot_q;
  logic                 run;
  logic                 first;
  logic                 fits;

  assign range_err = run & first & ({1'b0, rem_q} >= LIM);
  assign fits      = rem_q < DIV;
  assign done      = run & (range_err | fits);
  assign quot      = quot_q;
  assign rem       = rem_q[CW-1:0];

  // Load on start, then subtract RANGE until the remainder fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      run    <= 1'b0;
      first  <= 1'b0;
    end else if (start) begin
      rem_q  <= dividend;
      quot_q <= '0;
      run    <= 1'b1;
      first  <= 1'b1;
    end else if (run) begin
      first <= 1'b0;
      if (done) begin
        run <= 1'b0;
      end else begin
        rem_q  <= rem_q - DIV;
        quot_q <= quot_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/me_result_unpack.sv
// Captures the me_top result, decodes the linear index into x/y and signed
// displacements, and measures req-to-ack latency.
module me_result_unpack
  import me_pkg::*;
#(
  parameter int unsigned TB_LENGTH    = 16,
  parameter int unsigned SW_LENGTH    = 64,
  parameter int unsigned PE_OUT_WIDTH = 8,
  parameter int unsigned CYC_WIDTH    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  me_result_unpack_if.slave  bus
);
  localparam int unsigned RANGE     = range_f(TB_LENGTH, SW_LENGTH);
  localparam int unsigned CNT_WIDTH = cnt_width_f(TB_LENGTH, SW_LENGTH);
  localparam int unsigned SAD_WIDTH = sad_width_f(TB_LENGTH, PE_OUT_WIDTH);
  localparam int unsigned CW        = cw_f(TB_LENGTH, SW_LENGTH);
  localparam logic signed [CW:0] HALF = (CW+1)'((RANGE - 1) / 2);

  state_t               state, state_nx;
  logic                 req_d, req_rise;
  logic                 clear, count, capture, finish;
  logic [CYC_WIDTH-1:0] cnt, cnt_inc;

  logic                 out_valid_q, err_q;
  logic [SAD_WIDTH-1:0] sad_q;
  logic [CW-1:0]        x_q, y_q;
  logic signed [CW:0]   dx_q, dy_q;
  logic [CYC_WIDTH-1:0] cycles_q;

  logic                 div_done, div_err;
  logic [CW-1:0]        div_quot, div_rem;

  assign req_rise = bus.req & ~req_d;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

  me_idx_divider #(
    .RANGE    (RANGE),
    .CNT_WIDTH(CNT_WIDTH),
    .CW       (CW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (capture),
    .dividend (bus.min_mvec),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem),
    .range_err(div_err)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    count    = 1'b0;
    capture  = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (req_rise) begin
          clear    = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        count = 1'b1;
        if (!bus.req) begin
          state_nx = IDLE;
        end else if (bus.ack) begin
          capture  = 1'b1;
          state_nx = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latency counter, capture and decoded-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d       <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sad_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cycles_q    <= '0;
    end else begin
      req_d <= bus.req;
      if (clear) begin
        cnt         <= '0;
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
        cycles_q    <= '0;
      end
      if (count) cnt <= cnt_inc;
      if (capture) begin
        sad_q    <= bus.min_sad;
        cycles_q <= cnt_inc;
        err_q    <= (cnt == '1);
      end
      if (finish) begin
        out_valid_q <= 1'b1;
        if (div_err) begin
          x_q   <= '0;
          y_q   <= '0;
          dx_q  <= '0;
          dy_q  <= '0;
          err_q <= 1'b1;
        end else begin
          x_q  <= div_rem;
          y_q  <= div_quot;
          dx_q <= $signed({1'b0, div_rem}) - HALF;
          dy_q <= $signed({1'b0, div_quot}) - HALF;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.sad_q     = sad_q;
  assign bus.mvec_x    = x_q;
  assign bus.mvec_y    = y_q;
  assign bus.dx        = dx_q;
  assign bus.dy        = dy_q;
  assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_me_result_unpack.sv
// Bench for me_result_unpack: directed index table, random indices, abort,
// stale ack, async reset mid-divide and latency saturation.
module tb_me_result_unpack;
  localparam int RANGE = 49;
  localparam int HALF  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  me_result_unpack_if #(.CYC_WIDTH(24)) bus ();
  me_result_unpack_if #(.CYC_WIDTH(4))  sif ();

  me_result_unpack #(.TB_LENGTH(16), .SW_LENGTH(64), .PE_OUT_WIDTH(8), .CYC_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  me_result_unpack #(.TB_LENGTH(16), .SW_LENGTH(64), .PE_OUT_WIDTH(8), .CYC_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave)
  );

  // Reference decode from the row-major index rule.
  function automatic void model(input int idx, output int x, output int y, output int dxe,
                                output int dye, output bit e, output int lat);
    if (idx >= RANGE * RANGE) begin
      x = 0; y = 0; dxe = 0; dye = 0; e = 1'b1; lat = 1;
    end else begin
      x = idx % RANGE; y = idx / RANGE; dxe = x - HALF; dye = y - HALF; e = 1'b0; lat = y + 1;
    end
  endfunction

  // Drives one request; ack rises on the k-th WAIT_ACK cycle (or is held from before when stale).
  task automatic do_run(input int idx, input int sad, input int k, input bit stale,
                        output int lat, output bit ok);
    bus.req = 1'b0;
    bus.ack = stale;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.min_mvec = 12'(idx);
    bus.min_sad  = 16'(sad);
    bus.req = 1'b1;
    @(posedge clk); #1;
    if (!stale) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      bus.ack = 1'b1;
    end
    @(posedge clk); #1;
    lat = 0; ok = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = n; ok = 1'b1; break; end
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({bus.out_valid, bus.sad_q, bus.mvec_x, bus.mvec_y, bus.dx, bus.dy, bus.cycles, bus.err} !== '0)
      $display("FAIL reset_outputs: got ov=%b sad=%h x=%0d y=%0d cyc=%0d err=%b, want all zero",
               bus.out_valid, bus.sad_q, bus.mvec_x, bus.mvec_y, bus.cycles, bus.err);
    else pass_cnt++;
  endtask

  task automatic test_index_table();
    int idxs[4] = '{0, 1200, 2400, 3000};
    int ks[4]   = '{5, 7, 3, 4};
    int sads[4] = '{32'h1234, 32'hBEEF, 32'h0001, 32'hFFFF};
    int x, y, dxe, dye, lat_e, lat;
    bit e, ok;
    for (int i = 0; i < 4; i++) begin
      model(idxs[i], x, y, dxe, dye, e, lat_e);
      do_run(idxs[i], sads[i], ks[i], 1'b0, lat, ok);
      total_cnt++;
      if (!ok || lat != lat_e) $display("FAIL tbl_latency idx=%0d: got %0d (ok=%b), want %0d", idxs[i], lat, ok, lat_e);
      else pass_cnt++;
      total_cnt++;
      if (bus.mvec_x !== 6'(x) || bus.mvec_y !== 6'(y))
        $display("FAIL tbl_xy idx=%0d: got %0d,%0d want %0d,%0d", idxs[i], bus.mvec_x, bus.mvec_y, x, y);
      else pass_cnt++;
      total_cnt++;
      if ($signed(bus.dx) != dxe || $signed(bus.dy) != dye)
        $display("FAIL tbl_dxdy idx=%0d: got %0d,%0d want %0d,%0d", idxs[i], $signed(bus.dx), $signed(bus.dy), dxe, dye);
      else pass_cnt++;
      total_cnt++;
      if (bus.sad_q !== 16'(sads[i]) || bus.cycles !== 24'(ks[i]) || bus.err !== e)
        $display("FAIL tbl_sad_cyc_err idx=%0d: got sad=%h cyc=%0d err=%b want sad=%h cyc=%0d err=%b",
                 idxs[i], bus.sad_q, bus.cycles, bus.err, 16'(sads[i]), ks[i], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int idx, sad, k, x, y, dxe, dye, lat_e, lat;
    bit e, ok;
    for (int i = 0; i < 10; i++) begin
      idx = (i == 9) ? 2401 : $urandom_range(2600, 0);
      sad = $urandom_range(65535, 0);
      k   = $urandom_range(30, 1);
      model(idx, x, y, dxe, dye, e, lat_e);
      do_run(idx, sad, k, 1'b0, lat, ok);
      total_cnt++;
      if (!ok || lat != lat_e || bus.mvec_x !== 6'(x) || bus.mvec_y !== 6'(y) ||
          $signed(bus.dx) != dxe || $signed(bus.dy) != dye || bus.err !== e ||
          bus.cycles !== 24'(k) || bus.sad_q !== 16'(sad))
        $display("FAIL rand idx=%0d: got lat=%0d x=%0d y=%0d dx=%0d dy=%0d err=%b cyc=%0d sad=%h want lat=%0d x=%0d y=%0d dx=%0d dy=%0d err=%b cyc=%0d sad=%h",
                 idx, lat, bus.mvec_x, bus.mvec_y, $signed(bus.dx), $signed(bus.dy), bus.err, bus.cycles, bus.sad_q,
                 lat_e, x, y, dxe, dye, e, k, 16'(sad));
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int lat;
    bit ok;
    bus.req = 1'b0; bus.ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    bus.req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.cycles !== 24'd0)
      $display("FAIL abort_clear: got ov=%b cyc=%0d, want ov=0 cyc=0", bus.out_valid, bus.cycles);
    else pass_cnt++;
    do_run(100, 16'h5A5A, 100, 1'b0, lat, ok);
    total_cnt++;
    if (!ok || bus.cycles !== 24'd100 || bus.mvec_x !== 6'd2 || bus.mvec_y !== 6'd2)
      $display("FAIL abort_rerun: got ok=%b cyc=%0d x=%0d y=%0d, want cyc=100 x=2 y=2", ok, bus.cycles, bus.mvec_x, bus.mvec_y);
    else pass_cnt++;
  endtask

  task automatic test_stale_ack();
    int lat;
    bit ok;
    do_run(10, 16'h0A0A, 1, 1'b1, lat, ok);
    total_cnt++;
    if (!ok || bus.cycles !== 24'd1 || bus.mvec_x !== 6'd10 || bus.mvec_y !== 6'd0)
      $display("FAIL stale_first: got ok=%b cyc=%0d x=%0d y=%0d, want cyc=1 x=10 y=0", ok, bus.cycles, bus.mvec_x, bus.mvec_y);
    else pass_cnt++;
    // Second run: ack held high across the req rise, previous x must persist.
    bus.req = 1'b0; bus.ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.min_mvec = 12'(5 * RANGE + 3);
    bus.req = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.mvec_x !== 6'd10)
      $display("FAIL stale_hold: got ov=%b x=%0d, want ov=0 x=10", bus.out_valid, bus.mvec_x);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.cycles !== 24'd1 || bus.mvec_x !== 6'd10)
      $display("FAIL stale_capture: got cyc=%0d x=%0d, want cyc=1 x=10", bus.cycles, bus.mvec_x);
    else pass_cnt++;
    ok = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    bus.ack = 1'b0;
    total_cnt++;
    if (!ok || bus.mvec_x !== 6'd3 || bus.mvec_y !== 6'd5)
      $display("FAIL stale_second: got ok=%b x=%0d y=%0d, want x=3 y=5", ok, bus.mvec_x, bus.mvec_y);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_divide();
    int lat;
    bit ok;
    bus.req = 1'b0; bus.ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.min_mvec = 12'd2400; bus.min_sad = 16'h7777;
    bus.req = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    bus.ack = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.out_valid, bus.sad_q, bus.mvec_x, bus.mvec_y, bus.dx, bus.dy, bus.cycles, bus.err} !== '0)
      $display("FAIL reset_mid_divide: got ov=%b sad=%h x=%0d y=%0d cyc=%0d err=%b, want all zero",
               bus.out_valid, bus.sad_q, bus.mvec_x, bus.mvec_y, bus.cycles, bus.err);
    else pass_cnt++;
    bus.req = 1'b0; bus.ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_run(2400, 16'h7777, 3, 1'b0, lat, ok);
    total_cnt++;
    if (!ok || lat != 49 || bus.mvec_x !== 6'd48 || bus.mvec_y !== 6'd48 ||
        $signed(bus.dx) != 24 || $signed(bus.dy) != 24 || bus.cycles !== 24'd3 || bus.err !== 1'b0)
      $display("FAIL reset_rerun: got lat=%0d x=%0d y=%0d dx=%0d dy=%0d cyc=%0d err=%b, want lat=49 x=48 y=48 dx=24 dy=24 cyc=3 err=0",
               lat, bus.mvec_x, bus.mvec_y, $signed(bus.dx), $signed(bus.dy), bus.cycles, bus.err);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int ks[2] = '{20, 3};
    int cyc_e;
    bit err_e, ok;
    for (int i = 0; i < 2; i++) begin
      cyc_e = (ks[i] > 15) ? 15 : ks[i];
      err_e = (ks[i] > 15);
      sif.req = 1'b0; sif.ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      sif.min_mvec = 12'd50; sif.min_sad = 16'h0042;
      sif.req = 1'b1;
      @(posedge clk); #1;
      repeat (ks[i] - 1) begin @(posedge clk); #1; end
      sif.ack = 1'b1;
      @(posedge clk); #1;
      ok = 1'b0;
      for (int n = 1; n <= 80; n++) begin
        @(posedge clk); #1;
        if (sif.out_valid) begin ok = 1'b1; break; end
      end
      sif.ack = 1'b0;
      total_cnt++;
      if (!ok || sif.cycles !== 4'(cyc_e) || sif.err !== err_e || sif.mvec_x !== 6'd1 || sif.mvec_y !== 6'd1)
        $display("FAIL saturation k=%0d: got ok=%b cyc=%0d err=%b x=%0d y=%0d, want cyc=%0d err=%b x=1 y=1",
                 ks[i], ok, sif.cycles, sif.err, sif.mvec_x, sif.mvec_y, cyc_e, err_e);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.ack = 1'b0; bus.min_sad = '0; bus.min_mvec = '0;
    sif.req = 1'b0; sif.ack = 1'b0; sif.min_sad = '0; sif.min_mvec = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_index_table();
    test_random();
    test_abort();
    test_stale_ack();
    test_reset_mid_divide();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
